// File: rtl/lz77_pkg.sv
// lz77_pkg: shared constants, FSM state type and token record for the LZ77
// decoder slice.
//   SEARCH_LEN  history window depth (legal offsets 0..SEARCH_LEN-1)
//   OFS_W/LEN_W token field widths, MAX_MATCH largest legal match_len
//   FIFO_DEPTH  token FIFO entries, CNT_W output counter width
//   END_CHAR    end-of-stream literal
package lz77_pkg;

  localparam int unsigned SEARCH_LEN = 11;
  localparam int unsigned OFS_W      = 4;
  localparam int unsigned LEN_W      = 3;
  localparam int unsigned MAX_MATCH  = 4;
  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned CNT_W      = 12;
  localparam logic [7:0]  END_CHAR   = 8'h24;

  typedef enum logic [1:0] {IDLE, COPY, LIT, DONE} state_t;

  typedef struct packed {
    logic [OFS_W-1:0] ofs;
    logic [LEN_W-1:0] len;
    logic [7:0]       chr;
  } token_t;

  function automatic logic tok_legal(input token_t t);
    return (t.ofs <= OFS_W'(SEARCH_LEN - 1)) && (t.len <= LEN_W'(MAX_MATCH));
  endfunction

endpackage

// File: rtl/lz77_token_fifo.sv
// lz77_token_fifo: small synchronous token FIFO, asynchronous active-high reset.
//   clk, reset       clock / async reset
//   i_push, i_data   write strobe and token (ignored when full)
//   i_pop            read strobe (ignored when empty)
//   o_data           head-of-queue token (valid when !o_empty)
//   o_full, o_empty  occupancy flags
module lz77_token_fifo
  import lz77_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   i_push,
  input  token_t i_data,
  input  logic   i_pop,
  output token_t o_data,
  output logic   o_full,
  output logic   o_empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  token_t          r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_data  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/lz77_decoder.sv
// lz77_decoder: rebuilds the character stream from (offset, match_len, char_nxt)
// tokens, one character per cycle, using an 11-entry history window.
//   clk, reset                  clock / async active-high reset
//   valid, encode               token strobe; accepted when both high and ready
//   offset, match_len, char_nxt token fields
//   ready                       FIFO not full and stream not finished
//   out_valid, out_char         decoded character strobe / value
//   out_cnt                     characters emitted since reset (wraps)
//   finish, err                 sticky end-of-stream / protocol error flags
module lz77_decoder
  import lz77_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic             encode,
  input  logic [OFS_W-1:0] offset,
  input  logic [LEN_W-1:0] match_len,
  input  logic [7:0]       char_nxt,
  output logic             ready,
  output logic             out_valid,
  output logic [7:0]       out_char,
  output logic [CNT_W-1:0] out_cnt,
  output logic             finish,
  output logic             err
);

  state_t           r_state;
  state_t           w_next;
  logic [OFS_W-1:0] r_cur_ofs;
  logic [LEN_W-1:0] r_cur_len;
  logic [7:0]       r_cur_chr;
  logic [7:0]       r_hist [SEARCH_LEN];

  token_t w_in_tok;
  token_t w_head;
  logic   w_fifo_full;
  logic   w_fifo_empty;
  logic   w_tok_req;
  logic   w_push;
  logic   w_pop;
  logic   w_emit;
  logic   w_len_dec;
  logic   w_finish_set;
  logic [7:0] w_new_char;

  assign w_in_tok  = '{ofs: offset, len: match_len, chr: char_nxt};
  assign ready     = !w_fifo_full && (r_state != DONE);
  assign w_tok_req = valid && encode && (r_state != DONE);
  // Uses the registered full flag, so a token arriving at a full FIFO is
  // dropped even when the decoder pops on the same edge.
  assign w_push    = w_tok_req && tok_legal(w_in_tok) && !w_fifo_full;

  lz77_token_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_in_tok),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_pop        = 1'b0;
    w_emit       = 1'b0;
    w_len_dec    = 1'b0;
    w_finish_set = 1'b0;
    w_new_char   = r_cur_chr;
    case (r_state)
      IDLE: begin
        if (!w_fifo_empty) begin
          w_pop  = 1'b1;
          w_next = (w_head.len != '0) ? COPY : LIT;
        end
      end
      COPY: begin
        w_emit     = 1'b1;
        w_new_char = r_hist[r_cur_ofs];
        w_len_dec  = 1'b1;
        if (r_cur_len == LEN_W'(1)) w_next = LIT;
      end
      LIT: begin
        if (r_cur_chr == END_CHAR) begin
          w_finish_set = 1'b1;
          w_next       = DONE;
        end else begin
          w_emit = 1'b1;
          // Fetch the next token while emitting the literal to avoid a bubble.
          if (!w_fifo_empty) begin
            w_pop  = 1'b1;
            w_next = (w_head.len != '0) ? COPY : LIT;
          end else begin
            w_next = IDLE;
          end
        end
      end
      default: w_next = DONE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cur_ofs <= '0;
      r_cur_len <= '0;
      r_cur_chr <= '0;
      out_valid <= 1'b0;
      out_char  <= '0;
      out_cnt   <= '0;
      finish    <= 1'b0;
      err       <= 1'b0;
      for (int unsigned i = 0; i < SEARCH_LEN; i++) r_hist[i] <= '0;
    end else begin
      if (w_pop) begin
        r_cur_ofs <= w_head.ofs;
        r_cur_len <= w_head.len;
        r_cur_chr <= w_head.chr;
      end else if (w_len_dec) begin
        r_cur_len <= r_cur_len - 1'b1;
      end
      out_valid <= w_emit;
      if (w_emit) begin
        out_char  <= w_new_char;
        out_cnt   <= out_cnt + 1'b1;
        r_hist[0] <= w_new_char;
        for (int unsigned i = 1; i < SEARCH_LEN; i++) r_hist[i] <= r_hist[i-1];
      end
      if (w_finish_set) finish <= 1'b1;
      if (w_tok_req && (!tok_legal(w_in_tok) || w_fifo_full)) err <= 1'b1;
    end
  end

endmodule
